// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter: buffers one-cycle push strobes and shifts them out as 8N1 frames.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx_buffer #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH_LOG2  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_ready,
    input  logic [7:0]            sdata,
    output logic                  txd,
    output logic                  busy,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0] mem [DEPTH];

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [2:0]              bit_reg, bit_next;
    logic [7:0]              shift_reg, shift_next;
    logic                    txd_reg, txd_next;
    logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0]     level_reg, level_next;
    logic                    full_reg, busy_reg, busy_next;
    logic                    overflow_reg, overflow_next;
    logic                    pop, push, bit_last;
`ifdef UART_TX_PARITY_EN
    logic                    parity_reg, parity_next;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        txd_next   = txd_reg;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        bit_last = (cnt_reg == CNT_LAST);

        case (state_reg)
            IDLE: begin
                if (level_reg != '0) begin
                    pop        = 1'b1;
                    txd_next   = 1'b0;
                    cnt_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_last) begin
                    cnt_next   = '0;
                    txd_next   = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DATA: begin
                if (bit_last) begin
                    cnt_next = '0;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        txd_next   = parity_reg;
                        state_next = PARITY;
`else
                        txd_next   = 1'b1;
                        state_next = STOP;
`endif
                    end else begin
                        bit_next   = bit_reg + 3'd1;
                        txd_next   = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_last) begin
                    cnt_next   = '0;
                    txd_next   = 1'b1;
                    state_next = STOP;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
`endif
            STOP: begin
                if (bit_last) begin
                    cnt_next = '0;
                    // Chain straight into the next start bit so queued frames leave no idle gap.
                    if (level_reg != '0) begin
                        pop        = 1'b1;
                        txd_next   = 1'b0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) begin
            shift_next = mem[rd_ptr_reg];
`ifdef UART_TX_PARITY_EN
            parity_next = ^mem[rd_ptr_reg];
`endif
        end

        // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
        push          = tx_ready && ((level_reg != LVL_FULL) || pop);
        overflow_next = overflow_reg | (tx_ready & ~push);
        level_next    = level_reg + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
        busy_next     = (state_next != IDLE) || (level_next != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= sdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            full_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            overflow_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
            wr_ptr_reg   <= wr_ptr_reg + DEPTH_LOG2'(push);
            rd_ptr_reg   <= rd_ptr_reg + DEPTH_LOG2'(pop);
            level_reg    <= level_next;
            full_reg     <= (level_next == LVL_FULL);
            busy_reg     <= busy_next;
            overflow_reg <= overflow_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    assign txd      = txd_reg;
    assign busy     = busy_reg;
    assign full     = full_reg;
    assign level    = level_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: a frame-level occupancy model plus a UART receiver that pops expected bytes.
module tb_uart_tx_buffer;

    localparam int CPB   = 4;
    localparam int DL2   = 2;
    localparam int DEPTH = 1 << DL2;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tx_ready = 1'b0;
    logic [7:0]   sdata = 8'h00;
    logic         txd, busy, full, overflow;
    logic [DL2:0] level;

    uart_tx_buffer #(.CLK_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst(rst), .tx_ready(tx_ready), .sdata(sdata),
        .txd(txd), .busy(busy), .full(full), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: occupancy, in-flight frame timer and sticky overflow.
    logic [7:0] exp_q[$];
    int  m_lvl = 0;
    int  m_cnt = 0;
    bit  m_active = 1'b0;
    bit  m_ovf = 1'b0;
    int  cyc = 0;

    always @(posedge clk) begin
        bit m_pop, m_push;
        cyc++;
        if (rst) begin
            m_lvl = 0; m_cnt = 0; m_active = 1'b0; m_ovf = 1'b0;
            exp_q.delete();
        end else begin
            m_pop = (m_lvl != 0) && (!m_active || m_cnt == FRAME - 1);
            if (m_active) begin
                if (m_cnt == FRAME - 1) begin
                    if (m_pop) m_cnt = 0;
                    else m_active = 1'b0;
                end else begin
                    m_cnt++;
                end
            end else if (m_pop) begin
                m_active = 1'b1;
                m_cnt = 0;
            end
            m_push = tx_ready && (m_lvl < DEPTH || m_pop);
            if (tx_ready && !m_push) m_ovf = 1'b1;
            m_lvl = m_lvl + int'(m_push) - int'(m_pop);
            if (m_push) exp_q.push_back(sdata);
        end
    end

    bit chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("level", 32'(level), 32'(m_lvl));
            check("full", 32'(full), 32'(m_lvl == DEPTH));
            check("busy", 32'(busy), 32'(m_active || m_lvl != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            if (!m_active) check("txd_idle", 32'(txd), 32'd1);
        end
    end

    // Receiver: samples mid-bit, decodes frames, compares against the scoreboard queue.
    bit            rx_busy = 1'b0;
    int            rx_t = 0;
    logic [NB-1:0] rx_bits;
    int            frames = 0;
    int            start_times[$];
    bit            par_q[$];

    always @(negedge clk) begin
        logic [7:0] b;
        if (rst) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (chk_en && txd === 1'b0) begin
                rx_busy = 1'b1;
                rx_t = 0;
                start_times.push_back(cyc);
            end
        end else begin
            rx_t++;
        end
        if (rx_busy && (rx_t % CPB) == CPB / 2) begin
            rx_bits[rx_t / CPB] = txd;
            if (rx_t / CPB == NB - 1) begin
                b = rx_bits[8:1];
                check("start_bit", 32'(rx_bits[0]), 32'd0);
                check("stop_bit", 32'(rx_bits[NB-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
                check("parity_bit", 32'(rx_bits[9]), 32'(^b));
                par_q.push_back(rx_bits[9]);
`endif
                if (exp_q.size() == 0) check("rx_unexpected", 32'(b), 32'hFFFF_FFFF);
                else check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                frames++;
                rx_busy = 1'b0;
            end
        end
    end

    int lvl_peak = 0;

    task automatic push_byte(input logic [7:0] b);
        tx_ready = 1'b1;
        sdata = b;
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (int'(level) > lvl_peak) lvl_peak = int'(level);
            if (!m_active && m_lvl == 0 && !rx_busy && !busy) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_frame_cnt(input int n);
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (m_active && m_cnt == n) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!done) check("cnt_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] pat;
        int f0, s0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single 0xA5 frame: exact line waveform.
        pat = frame_bits(8'hA5);
        tx_ready = 1'b1; sdata = 8'hA5;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        check("a5_first_cycle", 32'(txd), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            check("a5_wave", 32'(txd), 32'(pat[k / CPB]));
        end
        @(posedge clk); #1;
        wait_idle();
        check("a5_frames", 32'(frames), 32'd1);

        // Three back-to-back bytes: no gaps, level peaks at 2.
        f0 = frames; s0 = start_times.size(); lvl_peak = 0;
        push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
        wait_idle();
        check("b2b_frames", 32'(frames - f0), 32'd3);
        check("b2b_peak", 32'(lvl_peak), 32'd2);
        if (start_times.size() >= s0 + 3) begin
            check("b2b_gap1", 32'(start_times[s0+1] - start_times[s0]), 32'(FRAME));
            check("b2b_gap2", 32'(start_times[s0+2] - start_times[s0+1]), 32'(FRAME));
        end else begin
            check("b2b_starts", 32'(start_times.size() - s0), 32'd3);
        end

        // Six pushes into a 4-deep FIFO: sixth byte dropped.
        f0 = frames;
        for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i));
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        wait_idle();
        check("ovf_frames", 32'(frames - f0), 32'd5);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO plus push on the STOP-final cycle: accepted alongside the pop.
        do_reset();
        f0 = frames;
        for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i));
        check("sp_full", 32'(full), 32'd1);
        wait_frame_cnt(FRAME - 1);
        push_byte(8'h25);
        check("sp_level", 32'(level), 32'd4);
        check("sp_overflow", 32'(overflow), 32'd0);
        wait_idle();
        check("sp_frames", 32'(frames - f0), 32'd6);

        // Reset during DATA bit 3 of 0xFF with two bytes queued.
        push_byte(8'hFF); push_byte(8'hAA); push_byte(8'h55);
        wait_frame_cnt(5 * CPB - 3);
        check("mid_bit3", 32'(txd), 32'd1);
        do_reset();
        check("mid_txd", 32'(txd), 32'd1);
        check("mid_level", 32'(level), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        f0 = frames;
        repeat (3 * FRAME) @(posedge clk);
        #1;
        check("mid_no_frames", 32'(frames - f0), 32'd0);

`ifdef UART_TX_PARITY_EN
        par_q.delete(); s0 = start_times.size();
        push_byte(8'h07); push_byte(8'h03);
        wait_idle();
        if (par_q.size() == 2) begin
            check("par_07", 32'(par_q[0]), 32'd1);
            check("par_03", 32'(par_q[1]), 32'd0);
            check("par_len", 32'(start_times[s0+1] - start_times[s0]), 32'd44);
        end else begin
            check("par_frames", 32'(par_q.size()), 32'd2);
        end
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
